// File: rtl/gcd_result_collector_pkg.sv
// Shared record type and plausibility check for the GCD result collector.
package gcd_result_collector_pkg;

  localparam int unsigned GCD_W = 4;

  typedef struct packed {
    logic [GCD_W-1:0] a;
    logic [GCD_W-1:0] b;
    logic [GCD_W-1:0] gcd;
    logic             err;
  } gcd_rec_t;

  // A result is implausible when the gcd cannot divide the operands' magnitude rules.
  function automatic logic gcd_plausible(input logic [GCD_W-1:0] a,
                                         input logic [GCD_W-1:0] b,
                                         input logic [GCD_W-1:0] gcd);
    logic bad;
    bad = ((gcd == '0) && ((a | b) != '0))
        || ((a != '0) && (gcd > a))
        || ((b != '0) && (gcd > b))
        || ((a == '0) && (b == '0) && (gcd != '0));
    return ~bad;
  endfunction

endpackage

// File: rtl/gcd_result_collector_if.sv
// Capture-side and consumer-side signals of the GCD result collector.
interface gcd_result_collector_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
);
  logic             res_valid_i;
  logic [W-1:0]     res_a_i;
  logic [W-1:0]     res_b_i;
  logic [W-1:0]     res_gcd_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [W-1:0]     out_a_o;
  logic [W-1:0]     out_b_o;
  logic [W-1:0]     out_gcd_o;
  logic             out_err_o;
  logic             full_o;
  logic [CNT_W-1:0] acc_cnt_o;
  logic [CNT_W-1:0] drop_cnt_o;

  modport master (
    output res_valid_i, res_a_i, res_b_i, res_gcd_i, out_ready_i,
    input  out_valid_o, out_a_o, out_b_o, out_gcd_o, out_err_o,
           full_o, acc_cnt_o, drop_cnt_o
  );

  modport slave (
    input  res_valid_i, res_a_i, res_b_i, res_gcd_i, out_ready_i,
    output out_valid_o, out_a_o, out_b_o, out_gcd_o, out_err_o,
           full_o, acc_cnt_o, drop_cnt_o
  );
endinterface

// File: rtl/gcd_result_collector_fifo.sv
// Register-array synchronous FIFO with wrap-bit pointers; caller gates push/pop.
module gcd_sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     wdata_i,
  output T     rdata_o,
  output logic empty_o,
  output logic full_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  T             mem_q [DEPTH];
  logic [AW:0]  wp_q, wp_d;
  logic [AW:0]  rp_q, rp_d;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (push_i) wp_d = wp_q + (AW+1)'(1);
    if (pop_i)  rp_d = rp_q + (AW+1)'(1);
  end

  // A full push+pop writes the slot being read this cycle; the read is combinational so it is safe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      if (push_i) mem_q[wp_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rp_q[AW-1:0]];
  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);

endmodule

// File: rtl/gcd_result_collector.sv
// Buffers completed GCD results in a FIFO, tags implausible ones, counts accepts and drops.
module gcd_result_collector
  import gcd_result_collector_pkg::*;
#(
  parameter int unsigned W     = GCD_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  gcd_result_collector_if.slave  bus
);
  logic             push, pop, empty, full;
  gcd_rec_t         wdata, head;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  always_comb begin
    wdata.a   = bus.res_a_i;
    wdata.b   = bus.res_b_i;
    wdata.gcd = bus.res_gcd_i;
    wdata.err = ~gcd_plausible(bus.res_a_i, bus.res_b_i, bus.res_gcd_i);
  end

  assign pop  = ~empty & bus.out_ready_i;
  assign push = bus.res_valid_i & (~full | pop);

  gcd_sync_fifo #(
    .T     (gcd_rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full)
  );

  always_comb begin
    acc_d  = acc_q;
    drop_d = drop_q;
    if (push) acc_d = acc_q + CNT_W'(1);
    if (bus.res_valid_i && !push && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      acc_q  <= acc_d;
      drop_q <= drop_d;
    end
  end

  assign bus.out_valid_o = ~empty;
  assign bus.out_a_o     = head.a;
  assign bus.out_b_o     = head.b;
  assign bus.out_gcd_o   = head.gcd;
  assign bus.out_err_o   = head.err;
  assign bus.full_o      = full;
  assign bus.acc_cnt_o   = acc_q;
  assign bus.drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_gcd_result_collector.sv
// Directed and random checks of gcd_result_collector against a queue-based reference model.
module tb_gcd_result_collector;
  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gcd_result_collector_if #(.W(W), .CNT_W(CNT_W)) bus ();

  gcd_result_collector #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int a;
    int b;
    int g;
    bit e;
  } rec_t;

  rec_t q[$];
  int   acc_m  = 0;
  int   drop_m = 0;
  bit   model_ok = 0;
  int   passed = 0;
  int   total  = 0;

  function automatic bit ref_err(int a, int b, int g);
    if (a == 0 && b == 0) return g != 0;
    if (g == 0) return 1;
    if (a != 0 && g > a) return 1;
    if (b != 0 && g > b) return 1;
    return 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic cycle(bit r, bit v, int a, int b, int g, bit rdy);
    bit pop, push;
    @(negedge clk);
    rst             = r;
    bus.res_valid_i = v;
    bus.res_a_i     = W'(a);
    bus.res_b_i     = W'(b);
    bus.res_gcd_i   = W'(g);
    bus.out_ready_i = rdy;
    #1;
    if (model_ok) begin
      chk("out_valid", bus.out_valid_o, q.size() > 0);
      chk("full", bus.full_o, q.size() == DEPTH);
      chk("acc_cnt", bus.acc_cnt_o, acc_m);
      chk("drop_cnt", bus.drop_cnt_o, drop_m);
      if (q.size() > 0) begin
        chk("head_a", bus.out_a_o, q[0].a);
        chk("head_b", bus.out_b_o, q[0].b);
        chk("head_gcd", bus.out_gcd_o, q[0].g);
        chk("head_err", bus.out_err_o, q[0].e);
      end
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      acc_m    = 0;
      drop_m   = 0;
      model_ok = 1;
    end else begin
      pop  = (q.size() > 0) && rdy;
      push = v && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{a: a, b: b, g: g, e: ref_err(a, b, g)});
        acc_m = (acc_m + 1) % 256;
      end else if (v && drop_m < 255) begin
        drop_m++;
      end
    end
  endtask

  initial begin
    int ra, rb, rg;
    bus.res_valid_i = 1'b0;
    bus.res_a_i     = '0;
    bus.res_b_i     = '0;
    bus.res_gcd_i   = '0;
    bus.out_ready_i = 1'b0;

    // Reset state
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    #1;
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_full", bus.full_o, 0);
    chk("rst_acc", bus.acc_cnt_o, 0);
    chk("rst_drop", bus.drop_cnt_o, 0);
    chk("rst_a", bus.out_a_o, 0);
    chk("rst_err", bus.out_err_o, 0);

    // 1: single push visible after the edge
    cycle(0, 1, 12, 8, 4, 0);
    #1;
    chk("t1_valid", bus.out_valid_o, 1);
    chk("t1_a", bus.out_a_o, 12);
    chk("t1_b", bus.out_b_o, 8);
    chk("t1_gcd", bus.out_gcd_o, 4);
    chk("t1_err", bus.out_err_o, 0);
    chk("t1_acc", bus.acc_cnt_o, 1);

    // 2: overflow with ready low, then ordered drain
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 1, i, i, i, 0);
    #1;
    chk("t2_full", bus.full_o, 1);
    cycle(0, 1, 5, 5, 5, 0);
    #1;
    chk("t2_drop", bus.drop_cnt_o, 1);
    chk("t2_full_after_drop", bus.full_o, 1);
    chk("t2_head", bus.out_a_o, 1);
    for (int i = 2; i <= 4; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      #1;
      chk("t2_drain_order", bus.out_a_o, i);
    end
    cycle(0, 0, 0, 0, 0, 1);
    #1;
    chk("t2_empty", bus.out_valid_o, 0);
    cycle(0, 0, 0, 0, 0, 1);  // ready on empty: nothing moves

    // 3: push and pop together while full
    for (int i = 1; i <= 4; i++) cycle(0, 1, i, i, i, 0);
    cycle(0, 1, 9, 3, 3, 1);
    #1;
    chk("t3_full", bus.full_o, 1);
    chk("t3_head", bus.out_a_o, 2);
    chk("t3_drop", bus.drop_cnt_o, 1);
    chk("t3_acc", bus.acc_cnt_o, 9);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

    // 4: plausibility flag
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 6, 9, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 4, 6, 5, 0);
    #1;
    chk("t4_err0", bus.out_err_o, 1);
    cycle(0, 0, 0, 0, 0, 1);
    #1;
    chk("t4_err1", bus.out_err_o, 0);
    cycle(0, 0, 0, 0, 0, 1);
    #1;
    chk("t4_err2", bus.out_err_o, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // 5: reset mid-operation discards contents
    for (int i = 1; i <= 3; i++) cycle(0, 1, i, 1, 1, 0);
    cycle(1, 1, 15, 15, 15, 0);
    #1;
    chk("t5_valid", bus.out_valid_o, 0);
    chk("t5_acc", bus.acc_cnt_o, 0);
    chk("t5_drop", bus.drop_cnt_o, 0);
    cycle(0, 1, 7, 14, 7, 0);
    cycle(0, 0, 0, 0, 0, 1);
    #1;
    chk("t5_alone", bus.out_valid_o, 0);

    // 6: random traffic, counter wrap, drop saturation
    for (int i = 0; i < 300; i++) begin
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      rg = int'($urandom_range(0, 15));
      cycle(0, $urandom_range(0, 1), ra, rb, rg, $urandom_range(0, 1));
    end
    for (int i = 0; i < 260; i++) begin
      ra = int'($urandom_range(0, 15));
      cycle(0, 1, ra, ra, ra, 1);
    end
    for (int i = 0; i < 270; i++) cycle(0, 1, 3, 6, 3, 0);
    #1;
    chk("t6_drop_sat", bus.drop_cnt_o, 255);
    chk("t6_acc", bus.acc_cnt_o, acc_m);
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
